// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   RESET_PC     : PCF value after reset
//   NOP_INSTR    : bubble instruction (MOV r0,r0) shown on InstrD when nothing valid
//   fetchState_t : fetch FSM encodings (REQ = may issue, WAIT = one request outstanding)
//   fetchEntry_t : decoded-stage payload {instruction word, PC + 8}
package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetchState_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response port.
//   imem_req    : request valid (master -> slave)
//   imem_addr   : word address of the request (master -> slave)
//   imem_gnt    : request accepted this cycle (slave -> master)
//   imem_rvalid : response valid, in order, one per granted request (slave -> master)
//   imem_rdata  : instruction word (slave -> master)
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_buffer.sv
// One-entry skid buffer holding a fetched {instr, pc8} that arrived while decode was stalled.
//   sys_clk   : clock
//   sys_rst_n : synchronous reset, active high
//   push      : store pushData (only issued while empty)
//   pop       : entry consumed by the IF/ID register
//   clear     : discard the entry (flush / redirect); wins over push and pop
//   pushData  : entry to store
//   popData   : stored entry
//   full      : entry present
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  fetchEntry_t pushData,
  output fetchEntry_t popData,
  output logic        full
);

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      full    <= 1'b0;
      popData <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full    <= 1'b1;
      popData <= pushData;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID pipeline register.
//   sys_clk, sys_rst_n       : clock, synchronous active-high reset
//   StallF, StallD, FlushD   : hazard controls
//   PCWrPendingF             : PC write in flight, freeze fetch
//   BranchTakenE/ALUResultE  : E-stage redirect (highest priority)
//   PCSrcW/ResultW           : W-stage PC write redirect
//   imem                     : instruction memory port (master)
//   PCF                      : current fetch PC
//   InstrD/PCPlus8D/InstrValidD : decode-stage instruction, its PC + 8, valid flag
//
// state | meaning
// REQ   | no request outstanding; may issue one at PCF
// WAIT  | one request outstanding; may issue the next on its rvalid cycle
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                StallF,
  input  logic                StallD,
  input  logic                FlushD,
  input  logic                PCWrPendingF,
  input  logic                BranchTakenE,
  input  logic [31:0]         ALUResultE,
  input  logic                PCSrcW,
  input  logic [31:0]         ResultW,
  fetch_unit_if.master        imem,
  output logic [31:0]         PCF,
  output logic [31:0]         InstrD,
  output logic [31:0]         PCPlus8D,
  output logic                InstrValidD
);

  fetchState_t state;
  logic        kill;
  logic [31:0] fetchPc;

  logic        redirect;
  logic        rvalidSeen;
  logic        rvalidLive;
  logic        issueSlot;
  logic        granted;
  logic        outstandingNext;
  logic        bufFull;
  logic        bufPush;
  logic        bufPop;
  logic        bufClear;
  fetchEntry_t bufIn;
  fetchEntry_t bufOut;

  assign redirect   = BranchTakenE | PCSrcW;
  assign rvalidSeen = imem.imem_rvalid & (state == WAIT);
  // A response returning in the redirect cycle is wrong-path as well.
  assign rvalidLive = rvalidSeen & ~kill & ~redirect;

  assign bufIn    = '{instr: imem.imem_rdata, pc8: fetchPc + 32'd8};
  assign bufPush  = rvalidLive & StallD & ~FlushD;
  assign bufPop   = bufFull & ~StallD & ~FlushD;
  assign bufClear = FlushD | redirect;

  // The request must react to gnt/rvalid in the same cycle for back-to-back
  // issue, so it is decoded from state rather than registered. Issue is also
  // held off in the cycle the buffer fills so a response never lands while full.
  assign issueSlot     = (state == REQ) | rvalidSeen;
  assign imem.imem_req = ~sys_rst_n & issueSlot & ~StallF & ~PCWrPendingF
                         & ~bufFull & ~bufPush;
  assign imem.imem_addr = {PCF[31:2], 2'b00};

  assign granted         = imem.imem_req & imem.imem_gnt;
  assign outstandingNext = granted | ((state == WAIT) & ~imem.imem_rvalid);

  fetch_buffer uBuf (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (bufPush),
    .pop       (bufPop),
    .clear     (bufClear),
    .pushData  (bufIn),
    .popData   (bufOut),
    .full      (bufFull)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state       <= REQ;
      kill        <= 1'b0;
      fetchPc     <= RESET_PC;
      PCF         <= RESET_PC;
      InstrD      <= NOP_INSTR;
      PCPlus8D    <= 32'd0;
      InstrValidD <= 1'b0;
    end else begin
      state <= outstandingNext ? WAIT : REQ;

      if (granted) fetchPc <= PCF;

      if (BranchTakenE)  PCF <= ALUResultE;
      else if (PCSrcW)   PCF <= ResultW;
      else if (granted)  PCF <= PCF + 32'd4;

      // Whatever is still outstanding after a redirect belongs to the old path.
      if (redirect)        kill <= outstandingNext;
      else if (rvalidSeen) kill <= 1'b0;

      if (FlushD) begin
        InstrD      <= NOP_INSTR;
        PCPlus8D    <= 32'd0;
        InstrValidD <= 1'b0;
      end else if (StallD) begin
        InstrD      <= InstrD;
      end else if (bufFull && !redirect) begin
        InstrD      <= bufOut.instr;
        PCPlus8D    <= bufOut.pc8;
        InstrValidD <= 1'b1;
      end else if (rvalidLive) begin
        InstrD      <= bufIn.instr;
        PCPlus8D    <= bufIn.pc8;
        InstrValidD <= 1'b1;
      end else begin
        InstrD      <= NOP_INSTR;
        PCPlus8D    <= 32'd0;
        InstrValidD <= 1'b0;
      end
    end
  end

endmodule
